// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// No logic, so no latency.
// No flow control lives here.
package regfile_pkg;

  // Default geometry of the 32x32 register file
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  // Write-arbiter sequencing: normal arbitration or zero sweep in progress
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_clr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above the pointer, with wrap.
// Grant is combinational (zero latency); the pointer updates on the clock edge after an advance strobe.
// enable=0 forces the grant to zero; the pointer only moves when the caller reports a completed transfer.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Search upward from the pointer; NUM_REQ is a power of two so index arithmetic wraps for free
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    if (!enable) begin
      grant = '0;
    end
  end

  // After a transfer the winner drops to lowest priority; otherwise the pointer holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ requesters and sweeps zeros on request.
// Accepted write appears on rf_* one cycle after the handshake; a sweep takes NUM_REGS cycles.
// req_ready is combinational, at most one bit high, and all low during a sweep or its start cycle.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int ZERO_PROTECT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       rf_reg_write,
  output logic [ADDR_W-1:0]          rf_write_reg,
  output logic [DATA_W-1:0]          rf_write_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int                IDX_W    = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  rf_clr_state_t      state;
  logic [ADDR_W-1:0]  sweep_cnt;   // index of the next sweep write to be driven
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               drop_write;

  // Arbitration runs only in IDLE outside a clear request; reset also silences ready
  assign arb_en = reset_n && (state == IDLE) && !clear_start;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .enable    (arb_en),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready  = grant;
  assign transfer   = |(req_valid & grant);
  assign clear_busy = (state == CLEAR);

  // Pick the winner's address and data from the packed request buses
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register 0 is hardwired in the file; accepted writes to it are consumed but not issued
  assign drop_write = (ZERO_PROTECT != 0) && (sel_addr == '0);

  // Sequencer plus registered write port: either forward the accepted write or step the sweep
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sweep_cnt     <= '0;
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      grant_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            // First sweep write (register 0) goes out the very next cycle
            state         <= CLEAR;
            rf_reg_write  <= 1'b1;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            grant_id      <= '0;
            sweep_cnt     <= ADDR_W'(1);
          end else if (transfer && !drop_write) begin
            rf_reg_write  <= 1'b1;
            rf_write_reg  <= sel_addr;
            rf_write_data <= sel_data;
            grant_id      <= grant_idx;
          end else begin
            rf_reg_write  <= 1'b0;
          end
        end
        CLEAR: begin
          if (rf_write_reg == LAST_REG) begin
            // Last register has just been driven; a clear_start seen here is ignored
            state        <= IDLE;
            rf_reg_write <= 1'b0;
            sweep_cnt    <= '0;
          end else begin
            rf_reg_write <= 1'b1;
            rf_write_reg <= sweep_cnt;
            sweep_cnt    <= sweep_cnt + ADDR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: cycle table plus hand sequences for reset and sweeps.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed from the arbitration and latency rules.
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic         clear_start;
  logic         clear_busy;
  logic         rf_reg_write;
  logic [4:0]   rf_write_reg;
  logic [31:0]  rf_write_data;
  logic [1:0]   grant_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NUM_REQ      (4),
    .DATA_W       (32),
    .ADDR_W       (5),
    .NUM_REGS     (32),
    .ZERO_PROTECT (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .grant_id      (grant_id)
  );

  typedef struct {
    logic [3:0]   valid;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [3:0]   ready;    // expected req_ready this cycle
    logic         we;       // expected rf_reg_write this cycle
    logic [4:0]   wreg;
    logic [31:0]  wdata;
    logic [1:0]   gid;
    logic         chk_rf;   // compare rf_write_reg/data (gid is compared whenever we=1)
  } vec_t;

  vec_t vecs[13];

  function automatic logic [19:0] pa(input logic [4:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] pd(input logic [31:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d,
                       input logic c);
    @(posedge clk);
    #1;
    req_valid   = v;
    req_addr    = a;
    req_data    = d;
    clear_start = c;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] r,
                          input logic [31:0] d, input logic [1:0] g);
    check({tag, "_we"},   32'(rf_reg_write),  32'(we));
    check({tag, "_reg"},  32'(rf_write_reg),  32'(r));
    check({tag, "_data"}, rf_write_data,      d);
    check({tag, "_gid"},  32'(grant_id),      32'(g));
  endtask

  initial begin
    // Cycle table, pointer starts at 0 after reset
    vecs[0]  = '{4'b0010, pa(0,0,5,0), pd(0,0,32'hDEADBEEF,0), 4'b0010, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1};
    vecs[1]  = '{4'b1000, pa(7,0,0,0), pd(32'h77,0,0,0),       4'b1000, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1, 1'b1};
    vecs[2]  = '{4'b1111, pa(4,3,2,1), pd(32'h44,32'h33,32'h22,32'h11), 4'b0001, 1'b1, 5'd7, 32'h77, 2'd3, 1'b1};
    vecs[3]  = '{4'b1111, pa(4,3,2,1), pd(32'h44,32'h33,32'h22,32'h55), 4'b0010, 1'b1, 5'd1, 32'h11, 2'd0, 1'b1};
    vecs[4]  = '{4'b1111, pa(4,3,2,1), pd(32'h44,32'h33,32'h22,32'h55), 4'b0100, 1'b1, 5'd2, 32'h22, 2'd1, 1'b1};
    vecs[5]  = '{4'b1111, pa(4,3,2,1), pd(32'h44,32'h33,32'h22,32'h55), 4'b1000, 1'b1, 5'd3, 32'h33, 2'd2, 1'b1};
    vecs[6]  = '{4'b1111, pa(4,3,2,1), pd(32'h44,32'h33,32'h22,32'h55), 4'b0001, 1'b1, 5'd4, 32'h44, 2'd3, 1'b1};
    vecs[7]  = '{4'b0000, pa(0,0,0,0), pd(0,0,0,0),            4'b0000, 1'b1, 5'd1, 32'h55,       2'd0, 1'b1};
    vecs[8]  = '{4'b0000, pa(0,0,0,0), pd(0,0,0,0),            4'b0000, 1'b0, 5'd1, 32'h55,       2'd0, 1'b1};
    vecs[9]  = '{4'b0100, pa(0,0,0,0), pd(0,32'h1234,0,0),     4'b0100, 1'b0, 5'd1, 32'h55,       2'd0, 1'b1};
    vecs[10] = '{4'b1100, pa(8,6,0,0), pd(32'h88,32'h66,0,0),  4'b1000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0};
    vecs[11] = '{4'b0100, pa(8,6,0,0), pd(32'h88,32'h66,0,0),  4'b0100, 1'b1, 5'd8, 32'h88,       2'd3, 1'b1};
    vecs[12] = '{4'b0000, pa(0,0,0,0), pd(0,0,0,0),            4'b0000, 1'b1, 5'd6, 32'h66,       2'd2, 1'b1};

    // Reset with every input asserted
    reset_n     = 1'b0;
    req_valid   = 4'b1111;
    req_addr    = pa(4,3,2,1);
    req_data    = pd(1,2,3,4);
    clear_start = 1'b1;
    #3;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_busy",  32'(clear_busy), 32'h0);
    check_rf("rst", 1'b0, 5'd0, 32'h0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_hold", 32'(req_ready), 32'h0);
    check_rf("rst_hold", 1'b0, 5'd0, 32'h0, 2'd0);
    req_valid   = 4'b0000;
    clear_start = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_we", 32'(rf_reg_write), 32'h0);
      check("idle_busy", 32'(clear_busy), 32'h0);
    end

    // Table-driven arbitration, latency and zero-protect
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d_we", i), 32'(rf_reg_write), 32'(vecs[i].we));
      if (vecs[i].chk_rf) begin
        check($sformatf("v%0d_reg", i), 32'(rf_write_reg), 32'(vecs[i].wreg));
        check($sformatf("v%0d_data", i), rf_write_data, vecs[i].wdata);
      end
      if (vecs[i].we) begin
        check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].gid));
      end
    end

    // Sweep with requester 2 waiting and a second clear_start mid-sweep; pointer is at 3
    drive(4'b0100, pa(0,9,0,0), pd(0,32'h99,0,0), 1'b1);
    @(negedge clk);
    check("clr_n_ready", 32'(req_ready), 32'h0);
    check("clr_n_busy", 32'(clear_busy), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      drive(4'b0100, pa(0,9,0,0), pd(0,32'h99,0,0), (k == 10));
      @(negedge clk);
      check($sformatf("clr%0d_ready", k), 32'(req_ready), 32'h0);
      check($sformatf("clr%0d_busy", k), 32'(clear_busy), 32'h1);
      check_rf($sformatf("clr%0d", k), 1'b1, 5'(k - 1), 32'h0, 2'd0);
    end
    drive(4'b0100, pa(0,9,0,0), pd(0,32'h99,0,0), 1'b0);
    @(negedge clk);
    check("clr_end_ready", 32'(req_ready), 32'h4);
    check("clr_end_busy", 32'(clear_busy), 32'h0);
    check("clr_end_we", 32'(rf_reg_write), 32'h0);
    drive(4'b0000, pa(0,0,0,0), pd(0,0,0,0), 1'b0);
    @(negedge clk);
    check_rf("post_clr", 1'b1, 5'd9, 32'h99, 2'd2);
    check("post_clr_busy", 32'(clear_busy), 32'h0);

    // Reset in the middle of a sweep
    drive(4'b0000, pa(0,0,0,0), pd(0,0,0,0), 1'b1);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      drive(4'b0000, pa(0,0,0,0), pd(0,0,0,0), 1'b0);
      @(negedge clk);
    end
    check_rf("pre_abort", 1'b1, 5'd9, 32'h0, 2'd0);
    req_valid = 4'b1111;
    #1;
    reset_n = 1'b0;
    #1;
    check_rf("abort", 1'b0, 5'd0, 32'h0, 2'd0);
    check("abort_busy", 32'(clear_busy), 32'h0);
    check("abort_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("after_abort%0d_we", c), 32'(rf_reg_write), 32'h0);
      check($sformatf("after_abort%0d_busy", c), 32'(clear_busy), 32'h0);
    end
    drive(4'b1111, pa(4,3,2,1), pd(32'h44,32'h33,32'h22,32'h11), 1'b0);
    @(negedge clk);
    check("ptr_restart_ready", 32'(req_ready), 32'h1);
    drive(4'b0000, pa(0,0,0,0), pd(0,0,0,0), 1'b0);
    @(negedge clk);
    check_rf("ptr_restart", 1'b1, 5'd1, 32'h11, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
